// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings and types for the load/store sequencer and its lane aligner.
package lsu_ctrl_pkg;

    localparam int INST_BUS_W = 32;
    localparam int REG_BUS_W  = 32;
    localparam int MEM_BUS_W  = 32;

    // funct3 load/store access types
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_MERR = 3'd4
    } lsu_state_e;

    // Request as latched from the MEM stage
    typedef struct packed {
        logic                   we;
        logic [2:0]             funct3;
        logic [MEM_BUS_W-1:0]   addr;
        logic [REG_BUS_W-1:0]   wdata;
    } lsu_req_t;

    // Unknown access codes behave as word accesses
    function automatic logic [2:0] lsu_norm(input logic [2:0] f3);
        case (f3)
            LSU_B, LSU_H, LSU_BU, LSU_HU: return f3;
            default:                      return LSU_W;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (lsu_norm(f3))
            LSU_H, LSU_HU: return off[0];
            LSU_W:         return |off;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data placement and load shift/extend.
// Purely combinational so it can be shared with a store buffer later.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic [31:0] shr;

    // Lane placement for stores, right-justify and extend for loads
    always_comb begin
        shr      = rword >> {offset, 3'b000};
        wdata_sh = wdata << {offset, 3'b000};
        be       = 4'b1111;
        rdata    = shr;
        case (lsu_norm(funct3))
            LSU_B: begin
                be    = 4'b0001 << offset;
                rdata = {{24{shr[7]}}, shr[7:0]};
            end
            LSU_BU: begin
                be    = 4'b0001 << offset;
                rdata = {24'h0, shr[7:0]};
            end
            LSU_H: begin
                be    = 4'b0011 << offset;
                rdata = {{16{shr[15]}}, shr[15:0]};
            end
            LSU_HU: begin
                be    = 4'b0011 << offset;
                rdata = {16'h0, shr[15:0]};
            end
            default: begin
                be    = 4'b1111;
                rdata = shr;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one MEM-stage request becomes one word-aligned RAM
// transaction; the pipeline is stalled until the completion pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_gnt_i,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    lsu_state_e  state_q, state_d;
    lsu_req_t    req_q;
    logic [31:0] rword_q;
    logic [7:0]  cnt_q;
    logic        err_q;

    logic        mis_in;
    logic        tmo;
    logic        capture;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] ld_data;

    assign mis_in  = lsu_misaligned(funct3_i, addr_i[1:0]);
    // Response wins over an expiring counter in the same cycle
    assign tmo     = (state_q == ST_WAIT) && !ram_rvalid_i && (cnt_q + 8'd1 == TO_LIM);
    assign capture = ram_rvalid_i &&
                     ((state_q == ST_WAIT) || (state_q == ST_REQ && ram_gnt_i));

    lsu_align u_align (
        .funct3   (req_q.funct3),
        .offset   (req_q.addr[1:0]),
        .wdata    (req_q.wdata),
        .rword    (rword_q),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i) state_d = mis_in ? ST_MERR : ST_REQ;
            ST_REQ:  if (ram_gnt_i) state_d = ram_rvalid_i ? ST_DONE : ST_WAIT;
            ST_WAIT: if (ram_rvalid_i || tmo) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_MERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request, captured read word, timeout counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rword_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_i && !mis_in)
                req_q <= '{we: we_i, funct3: funct3_i, addr: addr_i, wdata: wdata_i};
            if (capture)
                rword_q <= ram_rdata_i;
            cnt_q <= (state_q == ST_WAIT) ? cnt_q + 8'd1 : 8'd0;
            // Only set on the WAIT->DONE timeout edge, so it lives for the DONE cycle
            err_q <= tmo;
        end
    end

    // RAM-side fields are zero whenever no request is presented
    assign ram_req_o   = (state_q == ST_REQ);
    assign ram_we_o    = ram_req_o & req_q.we;
    assign ram_addr_o  = ram_req_o ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign ram_be_o    = ram_req_o ? be : 4'h0;
    assign ram_wdata_o = ram_req_o ? wdata_sh : 32'h0;

    assign done_o     = (state_q == ST_DONE) || (state_q == ST_MERR);
    assign misalign_o = (state_q == ST_MERR);
    assign err_o      = (state_q == ST_DONE) && err_q;
    assign rdata_o    = ((state_q == ST_DONE) && !req_q.we && !err_q) ? ld_data : 32'h0;

    // Combinational on req_i in IDLE so the request cycle itself is held
    assign stall_o = ((state_q == ST_IDLE) && req_i) ||
                     (state_q == ST_REQ) || (state_q == ST_WAIT);

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the data RAM. It sits between the MEM pipeline stage and the single data RAM port. It turns one load or store request into a word-aligned RAM transaction with byte enables and performs the valid/grant/response handshake. While the access is outstanding it holds the pipeline via a stall. It returns load data aligned and sign- or zero-extended, so MEM-stage data is ready for writeback.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles spent in WAIT before the access is aborted with an error. Legal range is 1..255; the counter is 8 bits.

Ports:
- clk, in, 1: the block's only clock.
- rstn, in, 1: reset, asynchronous and active-low.
- req_i, in, 1: MEM stage has a load or store. Held stable with all request fields while stall_o=1.
- we_i, in, 1: 1 = store, 0 = load.
- funct3_i, in, 3: access type. 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- addr_i, in, 32: byte address.
- wdata_i, in, 32: store data, right-justified (rs2).
- stall_o, out, 1: pipeline hold.
- done_o, out, 1: one-cycle completion pulse.
- rdata_o, out, 32: aligned and extended load data. Valid while done_o=1, otherwise 0.
- misalign_o, out, 1: pulses with done_o when the address is misaligned.
- err_o, out, 1: pulses with done_o on a RAM timeout.
- ram_req_o, out, 1: RAM request valid.
- ram_we_o, out, 1: RAM write.
- ram_addr_o, out, 32: {addr_i[31:2], 2'b00}.
- ram_be_o, out, 4: byte enables.
- ram_wdata_o, out, 32: store data shifted into its byte lanes.
- ram_gnt_i, in, 1: RAM accepts the request in this cycle.
- ram_rvalid_i, in, 1: RAM response. Load data is on ram_rdata_i; for a store it is the write acknowledge.
- ram_rdata_i, in, 32: RAM read word.

## Operation
States are IDLE, REQ, WAIT, DONE and MERR.

- **IDLE**
  - req_i=1 with an aligned address → REQ. The RAM-side fields are registered from the request.
  - req_i=1 with a misaligned address (H with addr[0]=1, or W with addr[1:0]≠0) → MERR. No RAM access is issued.
- **REQ**
  - ram_req_o=1 and the RAM-side fields are held constant.
  - ram_gnt_i=1 → WAIT.
  - If ram_gnt_i=1 and ram_rvalid_i=1 in the same cycle → DONE, with the data captured.
- **WAIT**
  - ram_rvalid_i=1 → DONE. ram_rdata_i is captured in this cycle.
  - The timeout counter increments each cycle. When it reaches TIMEOUT → DONE with err_o.
- **DONE**: done_o=1 → IDLE.
- **MERR**: done_o=1 and misalign_o=1 → IDLE.

Byte enables and write data:
- B: ram_be_o = 0001 << addr[1:0].
- H: ram_be_o = 0011 << addr[1:0].
- W: ram_be_o = 1111.
- ram_wdata_o = wdata_i << (8·addr[1:0]).

Load data:
- The captured word is shifted right by 8·addr[1:0].
- B and H sign-extend from bit 7 or bit 15.
- BU and HU zero-extend.
- On a store, err or misaligned completion, rdata_o=0.

stall_o behaviour:
- stall_o = (IDLE & req_i) | REQ | WAIT.
- stall_o is 0 in DONE and MERR, so the MEM stage advances in the done_o cycle.
- This makes stall_o combinational on req_i in IDLE.

Ignored and abort cases:
- ram_rvalid_i arriving in IDLE, DONE or MERR is ignored.
- req_i seen in DONE or MERR is not accepted; it is sampled again in the following IDLE.
- rstn low mid-transaction aborts immediately. A later RAM response is dropped because the block is in IDLE.

## Timing
- Reset values: state IDLE, counter 0, and every output 0. This includes ram_req_o, ram_be_o, ram_addr_o, ram_wdata_o, rdata_o and all pulses.
- Minimum latency is 3 cycles from req_i to done_o, with grant and response immediate:
  - c0: req_i=1.
  - c1: ram_req_o=1 and ram_gnt_i=1.
  - c2: ram_rvalid_i=1.
  - c3: done_o=1.
- Misaligned access: done_o=1 and misalign_o=1 at c1.
- Timeout: if ram_gnt_i at cycle g is followed by no response, err_o and done_o are asserted at g+TIMEOUT+1.
- There is no back-to-back issue. The earliest next ram_req_o is 2 cycles after done_o.

## Structure
- defines.v holds:
  - the funct3 load/store encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU);
  - the state encodings (3-bit);
  - the existing InstBus, RegBus and Membus widths (all 32).
- One sub-module is natural: lsu_align. It is purely combinational and covers be/wdata lane generation plus load shift and extend. It is reused by a future store-buffer.

## Test plan
- LB, addr=0x1003, RAM word 0x80_22_33_44, immediate grant and rvalid → ram_be_o=1000; done_o at c3; rdata_o=0xFFFFFF80; stall_o=1 for c0–c2 only.
- SH, addr=0x2002, wdata_i=0x0000ABCD → ram_addr_o=0x2000, ram_be_o=1100, ram_wdata_o=0xABCD0000, ram_we_o=1; done_o after rvalid; rdata_o=0.
- LW, addr=0x3001 → misalign_o=1 and done_o=1 at c1; ram_req_o never asserted.
- LHU, addr=0x4002, grant delayed 3 cycles, data 0x8001_1234 → ram_req_o held with stable fields for 4 cycles; rdata_o=0x00008001.
- TIMEOUT=4, grant given but no rvalid → err_o=1 and done_o=1 five cycles after grant; rdata_o=0.
- rstn pulsed low while in WAIT, then rvalid arrives → all outputs 0 immediately; no done_o; the stray rvalid is ignored.
